// File: rtl/tl_a_arbiter.sv
// -----------------------------------------------------------------------------
// tl_pkg / tl_a_arbiter
//
// Purpose:
//   N-to-1 TileLink arbiter for the A and D channels. Upstream A requests are
//   granted round-robin, and the grant is locked for the whole of a multi-beat
//   Put burst. The granted master index is written into the top IDX_W bits of
//   `source`, so D beats are routed back by `source` alone, with no response
//   queue.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   m_a_valid_i/_bits_i/_ready_o   per-master A channel (upstream)
//   m_d_valid_o/_bits_o/_ready_i   per-master D channel (index stripped)
//   s_a_valid_o/_bits_o/_ready_i   downstream A channel (index inserted)
//   s_d_valid_i/_bits_i/_ready_o   downstream D channel
//
// The A and D paths are purely combinational. Every output is held low while
// rst_ni is low.
// -----------------------------------------------------------------------------

package tl_pkg;

    localparam int SRC_W  = 8;
    localparam int SIZE_W = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int SINK_W = 1;

    typedef enum logic [2:0] {
        PUT_FULL_DATA    = 3'd0,
        PUT_PARTIAL_DATA = 3'd1,
        ARITHMETIC_DATA  = 3'd2,
        LOGICAL_DATA     = 3'd3,
        GET              = 3'd4,
        INTENT           = 3'd5
    } a_opcode_e;

    typedef struct packed {
        a_opcode_e             opcode;
        logic [2:0]            param;
        logic [SIZE_W-1:0]     size;
        logic [SRC_W-1:0]      source;
        logic [ADDR_W-1:0]     address;
        logic [DATA_W/8-1:0]   mask;
        logic [DATA_W-1:0]     data;
        logic                  corrupt;
    } A_chan_bits_t;

    typedef struct packed {
        logic [2:0]            opcode;
        logic [1:0]            param;
        logic [SIZE_W-1:0]     size;
        logic [SRC_W-1:0]      source;
        logic [SINK_W-1:0]     sink;
        logic                  denied;
        logic [DATA_W-1:0]     data;
        logic                  corrupt;
    } D_chan_bits_t;

endpackage

module tl_a_arbiter #(
    parameter int N_MST    = 4,
    parameter int IDX_W    = $clog2(N_MST),
    parameter int SRC_W    = tl_pkg::SRC_W,
    parameter int LOG_BEAT = 3,
    parameter int SIZE_W   = tl_pkg::SIZE_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic [N_MST-1:0]     m_a_valid_i,
    input  tl_pkg::A_chan_bits_t m_a_bits_i [N_MST],
    output logic [N_MST-1:0]     m_a_ready_o,

    output logic [N_MST-1:0]     m_d_valid_o,
    output tl_pkg::D_chan_bits_t m_d_bits_o [N_MST],
    input  logic [N_MST-1:0]     m_d_ready_i,

    output logic                 s_a_valid_o,
    output tl_pkg::A_chan_bits_t s_a_bits_o,
    input  logic                 s_a_ready_i,

    input  logic                 s_d_valid_i,
    input  tl_pkg::D_chan_bits_t s_d_bits_i,
    output logic                 s_d_ready_o
);

    // Largest burst is 1 << (2**SIZE_W - 1 - LOG_BEAT) beats.
    localparam int BEATS_W = (1 << SIZE_W) - LOG_BEAT;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]     gnt_q, gnt_d;
    logic [BEATS_W-1:0]   beats_q, beats_d;
    // An IDLE request that is presented but not yet accepted is pinned to
    // gnt_q, so that a newly-raised higher-priority valid cannot steal it.
    logic                 hold_q, hold_d;

    logic [IDX_W-1:0]     rr_sel;
    logic                 rr_found;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     sel;
    logic                 a_valid;
    logic                 a_hs;
    logic [BEATS_W-1:0]   first_beats;
    tl_pkg::A_chan_bits_t a_bits;

    logic [IDX_W-1:0]     d_idx;
    logic                 d_idx_ok;
    tl_pkg::D_chan_bits_t d_bits;

    // ------------------------------------------------------------------
    // Arbitration: cyclic search from rr_q, then grant lock / hold.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so that no path leaves it unassigned and infers a latch.
        rr_sel   = rr_q;
        rr_found = 1'b0;
        cand     = rr_q;
        for (int i = 0; i < N_MST; i++) begin
            cand = IDX_W'((int'(rr_q) + i) % N_MST);
            if (!rr_found && m_a_valid_i[cand]) begin
                rr_sel   = cand;
                rr_found = 1'b1;
            end
        end

        if (state_q == BURST) begin
            sel = gnt_q;
        end else if (hold_q && m_a_valid_i[gnt_q]) begin
            sel = gnt_q;
        end else begin
            sel = rr_sel;
        end
    end

    assign a_valid = rst_ni && m_a_valid_i[sel];
    assign a_hs    = a_valid && s_a_ready_i;

    // Multi-beat only for Put with more bytes than one bus beat.
    always_comb begin
        first_beats = BEATS_W'(1);
        if ((m_a_bits_i[sel].opcode == tl_pkg::PUT_FULL_DATA ||
             m_a_bits_i[sel].opcode == tl_pkg::PUT_PARTIAL_DATA) &&
            m_a_bits_i[sel].size > SIZE_W'(LOG_BEAT)) begin
            first_beats = BEATS_W'(1) << (m_a_bits_i[sel].size - SIZE_W'(LOG_BEAT));
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the same pre-edge values.
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            beats_q <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            beats_q <= beats_d;
            hold_q  <= hold_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        beats_d = beats_q;
        hold_d  = hold_q;

        unique case (state_q)
            IDLE: begin
                if (a_hs) begin
                    rr_d   = (int'(sel) == N_MST - 1) ? '0 : sel + 1'b1;
                    hold_d = 1'b0;
                    if (first_beats != BEATS_W'(1)) begin
                        state_d = BURST;
                        gnt_d   = sel;
                        beats_d = first_beats - 1'b1;
                    end
                end else if (a_valid) begin
                    hold_d = 1'b1;
                    gnt_d  = sel;
                end else begin
                    hold_d = 1'b0;
                end
            end
            BURST: begin
                if (a_hs) begin
                    beats_d = beats_q - 1'b1;
                    if (beats_q == BEATS_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: A mux and D demux
    // ------------------------------------------------------------------
    always_comb begin
        a_bits                             = m_a_bits_i[sel];
        a_bits.source[SRC_W-1 -: IDX_W]    = sel;

        s_a_valid_o      = a_valid;
        s_a_bits_o       = rst_ni ? a_bits : '0;
        m_a_ready_o      = '0;
        m_a_ready_o[sel] = rst_ni && s_a_ready_i;
    end

    assign d_idx    = s_d_bits_i.source[SRC_W-1 -: IDX_W];
    assign d_idx_ok = (int'(d_idx) < N_MST);

    always_comb begin
        d_bits                          = s_d_bits_i;
        d_bits.source[SRC_W-1 -: IDX_W] = '0;

        m_d_valid_o = '0;
        s_d_ready_o = 1'b0;
        for (int k = 0; k < N_MST; k++) begin
            m_d_bits_o[k] = rst_ni ? d_bits : '0;
        end

        if (rst_ni) begin
            if (d_idx_ok) begin
                m_d_valid_o[d_idx] = s_d_valid_i;
                s_d_ready_o        = m_d_ready_i[d_idx];
            end else begin
                // Out-of-range index: sink the beat so the bus cannot wedge.
                s_d_ready_o = 1'b1;
            end
        end
    end

    // A D beat addressed to a nonexistent master is a protocol error.
    d_idx_range_a: assert property (
        @(posedge clk_i) disable iff (!rst_ni) s_d_valid_i |-> d_idx_ok
    ) else $error("tl_a_arbiter: D source index out of range");

endmodule
